// File: rtl/ins_seq_decode.sv
// Sequenced instruction decoder: accepts an opcode over valid/ready, then holds
// a one-hot op line for a per-class number of execute steps; handles jumps, illegal ops and HALT.
module ins_seq_decode #(
  parameter int OPC_W    = 4,
  parameter int OPC_BASE = 4,
  parameter int ALU_OP0  = 8,
  parameter int JMP_OP   = 10,
  parameter int EXEC_CYC = 2,
  parameter int ALU_CYC  = 3,
  parameter int STEP_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    ir_valid,
  output logic                    ir_ready,
  input  logic [OPC_W-1:0]        ir,
  input  logic                    gt_flag,
  input  logic                    resume,
  output logic [(2**OPC_W)-1:0]   op_hot,
  output logic [STEP_W-1:0]       step,
  output logic                    jump_taken,
  output logic                    done,
  output logic                    illegal,
  output logic                    halted,
  output logic                    busy
);

  localparam int NOPS = 2**OPC_W;

  localparam logic [OPC_W-1:0]  BASE_C    = OPC_W'(OPC_BASE);
  localparam logic [OPC_W-1:0]  ADD_C     = OPC_W'(ALU_OP0);
  localparam logic [OPC_W-1:0]  SUB_C     = OPC_W'(ALU_OP0 + 1);
  localparam logic [OPC_W-1:0]  JMP_C     = OPC_W'(JMP_OP);
  localparam logic [OPC_W-1:0]  JG_C      = OPC_W'(JMP_OP + 1);
  localparam logic [OPC_W-1:0]  HALT_C    = '1;
  localparam logic [STEP_W-1:0] ALU_LAST  = STEP_W'(ALU_CYC - 1);
  localparam logic [STEP_W-1:0] EXEC_LAST = STEP_W'(EXEC_CYC - 1);
  localparam logic [NOPS-1:0]   HOT_ONE   = NOPS'(1);

  typedef enum logic [1:0] {IDLE, EXEC, HALTED} state_t;

  state_t             state;
  logic [STEP_W-1:0]  last_step_p0;
  logic               at_last;
  logic               accept;

  function automatic logic [STEP_W-1:0] last_step_of(input logic [OPC_W-1:0] opc);
    return (opc == ADD_C || opc == SUB_C) ? ALU_LAST : EXEC_LAST;
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return opc < BASE_C;
  endfunction

  assign at_last  = (state == EXEC) && (step == last_step_p0);
  assign ir_ready = en && ((state == IDLE) || at_last);
  assign done     = en && at_last;
  assign accept   = ir_valid && ir_ready;

  // Decode/execute stage: everything below advances only while en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_hot       <= '0;
      step         <= '0;
      last_step_p0 <= '0;
      jump_taken   <= 1'b0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
      busy         <= 1'b0;
    end else if (en) begin
      illegal <= 1'b0;
      if (accept) begin
        step <= '0;
        if (is_illegal(ir)) begin
          state      <= IDLE;
          op_hot     <= '0;
          jump_taken <= 1'b0;
          illegal    <= 1'b1;
          busy       <= 1'b0;
        end else if (ir == HALT_C) begin
          state      <= HALTED;
          op_hot     <= HOT_ONE << ir;
          jump_taken <= 1'b0;
          halted     <= 1'b1;
          busy       <= 1'b0;
        end else begin
          // Also the zero-bubble path when accepted on the last step.
          state        <= EXEC;
          op_hot       <= HOT_ONE << ir;
          last_step_p0 <= last_step_of(ir);
          jump_taken   <= (ir == JMP_C) || ((ir == JG_C) && gt_flag);
          busy         <= 1'b1;
        end
      end else begin
        case (state)
          EXEC: begin
            if (at_last) begin
              state      <= IDLE;
              op_hot     <= '0;
              jump_taken <= 1'b0;
              step       <= '0;
              busy       <= 1'b0;
            end else begin
              step <= step + 1'b1;
            end
          end
          HALTED: begin
            if (resume) begin
              state  <= IDLE;
              halted <= 1'b0;
              op_hot <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_seq_decode.sv
// Table-driven bench for ins_seq_decode: per-cycle input/expected-output records
// fed through a scoreboard queue, plus hand-written async reset sequences.
module tb_ins_seq_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ir_valid;
  logic        ir_ready;
  logic [3:0]  ir;
  logic        gt_flag;
  logic        resume;
  logic [15:0] op_hot;
  logic [3:0]  step;
  logic        jump_taken;
  logic        done;
  logic        illegal;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en, vld;
    logic [3:0]  ir;
    logic        gt, res;
    logic        rdy;
    logic [15:0] hot;
    logic [3:0]  stp;
    logic        jt, dn, ill, hlt, bsy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  ins_seq_decode dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir(ir), .gt_flag(gt_flag), .resume(resume), .op_hot(op_hot), .step(step),
    .jump_taken(jump_taken), .done(done), .illegal(illegal), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic e, v, input logic [3:0] i, input logic g, r,
                     input logic rdy, input logic [15:0] hot, input logic [3:0] stp,
                     input logic jt, dn, ill, hlt, bsy);
    vec_t t;
    t.en = e; t.vld = v; t.ir = i; t.gt = g; t.res = r;
    t.rdy = rdy; t.hot = hot; t.stp = stp; t.jt = jt; t.dn = dn;
    t.ill = ill; t.hlt = hlt; t.bsy = bsy;
    tbl.push_back(t);
  endtask

  function automatic logic [25:0] observed();
    return {ir_ready, op_hot, step, jump_taken, done, illegal, halted, busy};
  endfunction

  task automatic chk(input string name, input logic [25:0] act, input logic [25:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0; en = 1'b1; ir_valid = 1'b0; ir = '0; gt_flag = 1'b0; resume = 1'b0;

    // Idle shorthand: rdy=1, all other outputs 0.
    add(1,1,4,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h0010,0,0,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0010,1,0,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,8,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h0100,0,0,0,0,0,1);
    add(1,0,0,0,0, 0,16'h0100,1,0,0,0,0,1);
    add(1,1,9,0,0, 1,16'h0100,2,0,1,0,0,1);
    add(1,0,0,0,0, 0,16'h0200,0,0,0,0,0,1);
    add(1,0,0,0,0, 0,16'h0200,1,0,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0200,2,0,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,11,1,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h0800,0,1,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0800,1,1,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,11,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,1,0, 0,16'h0800,0,0,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0800,1,0,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,10,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h0400,0,1,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0400,1,1,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,2,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,1,0,0);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,15,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h8000,0,0,0,0,1,0);
    add(0,0,0,0,1, 0,16'h8000,0,0,0,0,1,0);
    add(1,0,0,0,0, 0,16'h8000,0,0,0,0,1,0);
    add(1,1,4,0,1, 0,16'h8000,0,0,0,0,1,0);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,1, 1,16'h0000,0,0,0,0,0,0);
    add(1,1,8,0,0, 1,16'h0000,0,0,0,0,0,0);
    add(1,0,0,0,0, 0,16'h0100,0,0,0,0,0,1);
    add(0,0,0,0,0, 0,16'h0100,1,0,0,0,0,1);
    add(0,0,0,0,0, 0,16'h0100,1,0,0,0,0,1);
    add(0,0,0,0,0, 0,16'h0100,1,0,0,0,0,1);
    add(1,0,0,0,0, 0,16'h0100,1,0,0,0,0,1);
    add(0,1,4,0,0, 0,16'h0100,2,0,0,0,0,1);
    add(1,0,0,0,0, 1,16'h0100,2,0,1,0,0,1);
    add(1,0,0,0,0, 1,16'h0000,0,0,0,0,0,0);

    #1 chk("reset_state", observed() & 26'h1FF_FFFF, 26'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      en = tbl[i].en; ir_valid = tbl[i].vld; ir = tbl[i].ir;
      gt_flag = tbl[i].gt; resume = tbl[i].res;
      exp_q.push_back(tbl[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d", i), observed(),
          {e.rdy, e.hot, e.stp, e.jt, e.dn, e.ill, e.hlt, e.bsy});
    end

    // Asynchronous reset in the middle of an add.
    @(negedge clk); en = 1'b1; ir_valid = 1'b1; ir = 4'd8;
    @(negedge clk); ir_valid = 1'b0;
    #2 chk("add_started", observed(), {1'b0, 16'h0100, 4'd0, 5'b00001});
    @(negedge clk);
    #2 chk("add_step1", observed(), {1'b0, 16'h0100, 4'd1, 5'b00001});
    rst_n = 1'b0;
    #1 chk("async_reset", observed(), {1'b1, 16'h0000, 4'd0, 5'b00000});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #2 chk("post_reset_idle", observed(), {1'b1, 16'h0000, 4'd0, 5'b00000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
